pwm_tick_gen: RTL and testbench
===============================

# pwm_tick_gen

Tick-driven PWM generator that consumes the divided clock produced by the team's clock divider (`clkout`), using each rising edge of it as a counting step in the system clock domain. Produces a PWM waveform with run-time programmable period and duty, double-buffered so that reloads take effect only at period boundaries. Sits directly downstream of the divider, in the same `clk` domain.

## Interface
- `N`, 8, width of the period, duty and step counter.

- `clk`  input  1  system clock; all logic is on its rising edge.
- `n_reset`  input  1  asynchronous, active-low reset.
- `enable`  input  1  run enable; low forces IDLE.
- `tick_in`  input  1  divided clock from the divider; synchronous to `clk`, any high time.
- `period`  input  N  PWM period in steps; 0 means stopped.
- `duty`  input  N  high time in steps.
- `load`  input  1  one-cycle strobe; captures `period` and `duty`.
- `pwm_out`  output  1  PWM waveform.
- `cycle_done`  output  1  one-`clk` pulse at each period wrap.

## Operation
- Reset values: `pwm_out`=0 (1 with `PWM_POL_INV_EN`), `cycle_done`=0, `cnt`=0, `tick_d`=0, `period_act`=0, `duty_act`=0, `pend`=0, state IDLE.
- Step detect: `step = tick_in & ~tick_d & enable`, with `tick_d` a register of `tick_in`. A high level spanning many cycles counts exactly once.
- Load: `load`=1 copies `period`/`duty` into pending registers and sets `pend`. A later load before apply overwrites the pending values (last wins).
- FSM IDLE:
  - `cnt` held at 0, `pwm_out` at idle level.
  - If `pend`, pending values move to active next edge and `pend` clears.
  - To RUN when `enable`=1 and `period_act`!=0.
- FSM RUN, on `step`:
  - If `cnt`==`period_act`-1, then `cnt`<=0 and `cycle_done`<=1 for one cycle.
  - At that wrap, if `pend`, apply pending to active. If `load` is also asserted the same cycle, the incoming `period`/`duty` are applied directly instead.
  - Otherwise `cnt`<=`cnt`+1.
- Leaving RUN:
  - `enable`=0 in RUN goes to IDLE next edge; `cnt` cleared, pending retained.
  - Active period 0 after an apply goes to IDLE.
- `pwm_out` is high in RUN when `cnt` < `duty_act` (unsigned N-bit compare), else low.
  - `duty_act`=0 gives constant low.
  - `duty_act` >= `period_act` gives constant high; no glitch at wrap.
- `cnt` never exceeds `period_act`-1. For period=1, every step is a wrap.

## Timing
- Step latency: `tick_in` sampled high with `tick_d` low at edge k updates `cnt`, `pwm_out` and `cycle_done` at edge k.
- `pwm_out` is a function of registered state only, with no input-to-output combinational path.
- IDLE→RUN takes one edge. `pwm_out` rises at that edge if `duty_act`>0.
- Load in IDLE: values become active 1 edge later, and RUN is entered at the edge after that.
- `cycle_done` is high for exactly one `clk` per wrap.
- `n_reset` low forces all outputs to reset values immediately, independent of `clk`. Active and pending values are lost, so software must reload.

## Configuration
- `PWM_POL_INV_EN`:
  - Defined: `pwm_out` is inverted; idle and reset level is 1, and the active phase (`cnt` < `duty_act`) drives 0.
  - Undefined: polarity as in Operation.
  - `cycle_done` is unaffected either way.

## Test plan
- Reset: hold `n_reset`=0, toggle `tick_in`, `enable`=1 → `pwm_out`=0, `cycle_done`=0, no RUN entry. Release with `period_act` still 0 → remains IDLE.
- Basic: N=8, load period=4, duty=1, `enable`=1, `tick_in` rising every 4 clk (high 2, low 2) → `pwm_out` high 4 clk, low 12 clk, repeating. `cycle_done` pulses every 16 clk, coincident with `pwm_out` rising.
- Reload mid-period: in RUN with period=4, duty=1, load period=2, duty=2 at `cnt`=1 → current period finishes unchanged, then `pwm_out` is constant high and `cycle_done` pulses every 8 clk.
- Boundaries:
  - duty=5, period=4 → `pwm_out` constant 1.
  - duty=0 → constant 0.
  - period=1, duty=1 → constant 1 with `cycle_done` on every step.
  - `load` coincident with a wrap → the new values are used from that wrap.
- Enable drop: deassert `enable` at `cnt`=2 → next edge `pwm_out`=0 and `cnt`=0. Re-enable → restarts at `cnt`=0; a `tick_in` held high across the drop is not counted twice.
- Async reset mid-period: pulse `n_reset` low between `clk` edges at `cnt`=3 → `pwm_out` drops immediately. After release, IDLE until a new `load`. Repeat with `PWM_POL_INV_EN` defined → `pwm_out` goes to 1.

Source files
------------

// File: rtl/pwm_tick_gen.sv
// Tick-driven PWM generator with double-buffered period/duty reload.
// Define PWM_POL_INV_EN to invert pwm_out (idle/reset level 1).
module pwm_tick_gen #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         enable,
    input  logic         tick_in,
    input  logic [N-1:0] period,
    input  logic [N-1:0] duty,
    input  logic         load,
    output logic         pwm_out,
    output logic         cycle_done
);

    localparam logic [N-1:0] ZERO = '0;
    localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t       state;
    logic         tick_d;
    logic         pend;
    logic [N-1:0] cnt;
    logic [N-1:0] period_act;
    logic [N-1:0] duty_act;
    logic [N-1:0] period_pend;
    logic [N-1:0] duty_pend;
    logic         step;
    logic         wrap;
    logic         pwm_hi;

    assign step = tick_in & ~tick_d & enable;
    assign wrap = (cnt == period_act - ONE);

    // Output decoded from registers only, so async reset reaches it at once
    assign pwm_hi = (state == RUN) && (cnt < duty_act);

`ifdef PWM_POL_INV_EN
    assign pwm_out = ~pwm_hi;
`else
    assign pwm_out = pwm_hi;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= IDLE;
            tick_d      <= 1'b0;
            pend        <= 1'b0;
            cnt         <= ZERO;
            period_act  <= ZERO;
            duty_act    <= ZERO;
            period_pend <= ZERO;
            duty_pend   <= ZERO;
            cycle_done  <= 1'b0;
        end else begin
            tick_d     <= tick_in;
            cycle_done <= 1'b0;

            if (load) begin
                period_pend <= period;
                duty_pend   <= duty;
                pend        <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    cnt <= ZERO;
                    // Pending values land first; RUN is entered the edge after
                    if (pend) begin
                        period_act <= period_pend;
                        duty_act   <= duty_pend;
                        if (!load) begin
                            pend <= 1'b0;
                        end
                    end else if (enable && period_act != ZERO) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state <= IDLE;
                        cnt   <= ZERO;
                    end else if (step) begin
                        if (wrap) begin
                            cnt        <= ZERO;
                            cycle_done <= 1'b1;
                            if (load) begin
                                period_act <= period;
                                duty_act   <= duty;
                                pend       <= 1'b0;
                                if (period == ZERO) begin
                                    state <= IDLE;
                                end
                            end else if (pend) begin
                                period_act <= period_pend;
                                duty_act   <= duty_pend;
                                pend       <= 1'b0;
                                if (period_pend == ZERO) begin
                                    state <= IDLE;
                                end
                            end
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_tick_gen.sv
// Directed, table-driven bench for pwm_tick_gen.
// Expected levels follow PWM_POL_INV_EN when it is defined.
module tb_pwm_tick_gen;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       enable = 1'b0;
    logic       tick_in = 1'b0;
    logic [7:0] period = 8'd0;
    logic [7:0] duty = 8'd0;
    logic       load = 1'b0;
    logic       pwm_out;
    logic       cycle_done;

    int checks = 0;
    int errors = 0;

    pwm_tick_gen #(.N(8)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .enable     (enable),
        .tick_in    (tick_in),
        .period     (period),
        .duty       (duty),
        .load       (load),
        .pwm_out    (pwm_out),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] per;
        logic [7:0] dut;
        logic       entry;
        logic [7:0] pwm_pat;
        logic [7:0] done_pat;
    } vec_t;

    vec_t vecs [6];

    function automatic logic lvl(input logic hi);
`ifdef PWM_POL_INV_EN
        return ~hi;
`else
        return hi;
`endif
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b want %0b", name, act, exp);
        end
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        enable  = 1'b0;
        load    = 1'b0;
        tick_in = 1'b0;
        period  = 8'd0;
        duty    = 8'd0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
    endtask

    // Load in IDLE: apply one edge later, RUN the edge after that
    task automatic start(input logic [7:0] p, input logic [7:0] d);
        @(negedge clk);
        load   = 1'b1;
        period = p;
        duty   = d;
        enable = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(posedge clk);
        #1 chk("idle_before_run", pwm_out, lvl(1'b0));
        @(posedge clk);
        #1;
    endtask

    // One tick: 2 clk high, 2 clk low
    task automatic step_chk(input string name, input logic ep,
                            input logic ed);
        @(negedge clk);
        tick_in = 1'b1;
        @(posedge clk);
        #1;
        chk({name, "_pwm"}, pwm_out, ep);
        chk({name, "_done"}, cycle_done, ed);
        @(posedge clk);
        #1;
        chk({name, "_pwm_hold"}, pwm_out, ep);
        chk({name, "_done_pulse"}, cycle_done, 1'b0);
        @(negedge clk);
        tick_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{8'd4, 8'd1, 1'b1, 8'b1000_1000, 8'b1000_1000};
        vecs[1] = '{8'd4, 8'd5, 1'b1, 8'b1111_1111, 8'b1000_1000};
        vecs[2] = '{8'd4, 8'd0, 1'b0, 8'b0000_0000, 8'b1000_1000};
        vecs[3] = '{8'd1, 8'd1, 1'b1, 8'b1111_1111, 8'b1111_1111};
        vecs[4] = '{8'd3, 8'd2, 1'b1, 8'b0110_1101, 8'b0010_0100};
        vecs[5] = '{8'd2, 8'd1, 1'b1, 8'b1010_1010, 8'b1010_1010};

        // Reset held: activity ignored
        n_reset = 1'b0;
        enable  = 1'b1;
        load    = 1'b1;
        period  = 8'd4;
        duty    = 8'd4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tick_in = ~tick_in;
            @(posedge clk);
            #1;
            chk("rst_pwm", pwm_out, lvl(1'b0));
            chk("rst_done", cycle_done, 1'b0);
        end
        @(negedge clk);
        load    = 1'b0;
        tick_in = 1'b0;
        n_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step_chk("rst_idle", lvl(1'b0), 1'b0);
        end

        // Table of period/duty patterns
        for (int v = 0; v < 6; v++) begin
            do_reset();
            start(vecs[v].per, vecs[v].dut);
            chk($sformatf("v%0d_entry", v), pwm_out, lvl(vecs[v].entry));
            for (int s = 0; s < 8; s++) begin
                step_chk($sformatf("v%0d_s%0d", v, s + 1),
                         lvl(vecs[v].pwm_pat[s]), vecs[v].done_pat[s]);
            end
        end

        // Reload mid-period takes effect at the wrap
        do_reset();
        start(8'd4, 8'd1);
        step_chk("rl1", lvl(1'b0), 1'b0);
        @(negedge clk);
        load   = 1'b1;
        period = 8'd2;
        duty   = 8'd2;
        @(negedge clk);
        load = 1'b0;
        step_chk("rl2", lvl(1'b0), 1'b0);
        step_chk("rl3", lvl(1'b0), 1'b0);
        step_chk("rl4", lvl(1'b1), 1'b1);
        step_chk("rl5", lvl(1'b1), 1'b0);
        step_chk("rl6", lvl(1'b1), 1'b1);

        // Load coincident with wrap applies immediately
        do_reset();
        start(8'd4, 8'd1);
        step_chk("cw_a", lvl(1'b0), 1'b0);
        step_chk("cw_b", lvl(1'b0), 1'b0);
        step_chk("cw_c", lvl(1'b0), 1'b0);
        @(negedge clk);
        tick_in = 1'b1;
        load    = 1'b1;
        period  = 8'd2;
        duty    = 8'd0;
        @(posedge clk);
        #1;
        chk("cw_wrap_pwm", pwm_out, lvl(1'b0));
        chk("cw_wrap_done", cycle_done, 1'b1);
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        tick_in = 1'b0;
        repeat (2) @(negedge clk);
        step_chk("cw1", lvl(1'b0), 1'b0);
        step_chk("cw2", lvl(1'b0), 1'b1);

        // Enable drop with tick held high across it
        do_reset();
        start(8'd4, 8'd3);
        chk("ed_entry", pwm_out, lvl(1'b1));
        step_chk("ed1", lvl(1'b1), 1'b0);
        step_chk("ed2", lvl(1'b1), 1'b0);
        @(negedge clk);
        tick_in = 1'b1;
        enable  = 1'b0;
        @(posedge clk);
        #1;
        chk("ed_drop_pwm", pwm_out, lvl(1'b0));
        chk("ed_drop_done", cycle_done, 1'b0);
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1;
        chk("ed_reen_pwm", pwm_out, lvl(1'b1));
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("ed_held_pwm", pwm_out, lvl(1'b1));
            chk("ed_held_done", cycle_done, 1'b0);
        end
        @(negedge clk);
        tick_in = 1'b0;
        repeat (2) @(negedge clk);
        step_chk("ed3", lvl(1'b1), 1'b0);
        step_chk("ed4", lvl(1'b1), 1'b0);
        step_chk("ed5", lvl(1'b0), 1'b0);
        step_chk("ed6", lvl(1'b1), 1'b1);

        // Async reset between edges at cnt=3
        do_reset();
        start(8'd4, 8'd4);
        step_chk("ar1", lvl(1'b1), 1'b0);
        step_chk("ar2", lvl(1'b1), 1'b0);
        step_chk("ar3", lvl(1'b1), 1'b0);
        @(posedge clk);
        #2;
        chk("ar_before", pwm_out, lvl(1'b1));
        n_reset = 1'b0;
        #1;
        chk("ar_async_pwm", pwm_out, lvl(1'b0));
        chk("ar_async_done", cycle_done, 1'b0);
        @(negedge clk);
        n_reset = 1'b1;
        step_chk("ar_idle1", lvl(1'b0), 1'b0);
        step_chk("ar_idle2", lvl(1'b0), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
